// File: rtl/cpu64_l1_pkg.sv
// Shared L1 definitions: way geometry, refill FSM states and release type encodings.
package cpu64_l1_pkg;

  localparam int NUM_WAYS = 8;
  localparam int WAY_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VICT,
    ST_TAGRD,
    ST_REL,
    ST_REL_WAIT,
    ST_ACQ,
    ST_ACQ_WAIT,
    ST_INST
  } refill_state_e;

  localparam logic REL_CLEAN = 1'b0;
  localparam logic REL_DIRTY = 1'b1;

endpackage

// File: rtl/cpu64_l1_refill_ctrl_if.sv
// Miss, PLRU/tag-array, release (C) and acquire (A/D) signals of the L1 refill controller.
interface cpu64_l1_refill_ctrl_if
  import cpu64_l1_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 20
);
  logic                miss_valid_i;
  logic                miss_ready_o;
  logic [INDEX_W-1:0]  miss_set_i;
  logic [TAG_W-1:0]    miss_tag_i;
  logic [INDEX_W-1:0]  plru_set_o;
  logic [WAY_W-1:0]    victim_i;
  logic [NUM_WAYS-1:0] valid_i;
  logic [NUM_WAYS-1:0] dirty_i;
  logic                tag_rd_en_o;
  logic [WAY_W-1:0]    tag_rd_way_o;
  logic [TAG_W-1:0]    tag_rd_data_i;
  logic                rel_valid_o;
  logic                rel_ready_i;
  logic [TAG_W-1:0]    rel_tag_o;
  logic [WAY_W-1:0]    rel_way_o;
  logic                rel_data_o;
  logic                rel_ack_i;
  logic                acq_valid_o;
  logic                acq_ready_i;
  logic [TAG_W-1:0]    acq_tag_o;
  logic [WAY_W-1:0]    acq_way_o;
  logic                grant_done_i;
  logic                inst_we_o;
  logic [WAY_W-1:0]    inst_way_o;
  logic [TAG_W-1:0]    inst_tag_o;
  logic                plru_access_o;
  logic [WAY_W-1:0]    plru_way_o;
  logic                done_o;

  modport ctrl (
    input  miss_valid_i, miss_set_i, miss_tag_i, victim_i, valid_i, dirty_i,
           tag_rd_data_i, rel_ready_i, rel_ack_i, acq_ready_i, grant_done_i,
    output miss_ready_o, plru_set_o, tag_rd_en_o, tag_rd_way_o, rel_valid_o,
           rel_tag_o, rel_way_o, rel_data_o, acq_valid_o, acq_tag_o, acq_way_o,
           inst_we_o, inst_way_o, inst_tag_o, plru_access_o, plru_way_o, done_o
  );

  modport env (
    output miss_valid_i, miss_set_i, miss_tag_i, victim_i, valid_i, dirty_i,
           tag_rd_data_i, rel_ready_i, rel_ack_i, acq_ready_i, grant_done_i,
    input  miss_ready_o, plru_set_o, tag_rd_en_o, tag_rd_way_o, rel_valid_o,
           rel_tag_o, rel_way_o, rel_data_o, acq_valid_o, acq_tag_o, acq_way_o,
           inst_we_o, inst_way_o, inst_tag_o, plru_access_o, plru_way_o, done_o
  );
endinterface

// File: rtl/cpu64_l1_refill_ctrl.sv
// L1 miss handler: freezes the PLRU victim, releases it if valid, acquires the line and installs it.
//
// state       | meaning
// IDLE        | ready for a miss
// VICT        | sample PLRU victim and its valid/dirty bits
// TAGRD       | capture victim tag from the tag array
// REL         | release request held until accepted
// REL_WAIT    | waiting for ReleaseAck
// ACQ         | acquire request held until accepted
// ACQ_WAIT    | waiting for last grant beat
// INST        | tag write, PLRU update, done pulse
module cpu64_l1_refill_ctrl
  import cpu64_l1_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 20
) (
  input logic                  clk_i,
  input logic                  rst_i,
  cpu64_l1_refill_ctrl_if.ctrl bus
);

  refill_state_e      state_q, state_d;
  logic [INDEX_W-1:0] set_q;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   vtag_q;
  logic [WAY_W-1:0]   victim_q;
  logic               dirty_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      set_q    <= '0;
      tag_q    <= '0;
      vtag_q   <= '0;
      victim_q <= '0;
      dirty_q  <= REL_CLEAN;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.miss_valid_i) begin
        set_q <= bus.miss_set_i;
        tag_q <= bus.miss_tag_i;
      end
      // Victim is frozen here; later PLRU movement must not redirect the refill.
      if (state_q == ST_VICT) begin
        victim_q <= bus.victim_i;
        dirty_q  <= bus.dirty_i[bus.victim_i];
      end
      if (state_q == ST_TAGRD) vtag_q <= bus.tag_rd_data_i;
    end
  end

  always_comb begin
    state_d           = state_q;
    bus.miss_ready_o  = 1'b0;
    bus.plru_set_o    = set_q;
    bus.tag_rd_en_o   = 1'b0;
    bus.tag_rd_way_o  = '0;
    bus.rel_valid_o   = 1'b0;
    bus.rel_tag_o     = '0;
    bus.rel_way_o     = '0;
    bus.rel_data_o    = REL_CLEAN;
    bus.acq_valid_o   = 1'b0;
    bus.acq_tag_o     = '0;
    bus.acq_way_o     = '0;
    bus.inst_we_o     = 1'b0;
    bus.inst_way_o    = '0;
    bus.inst_tag_o    = '0;
    bus.plru_access_o = 1'b0;
    bus.plru_way_o    = '0;
    bus.done_o        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bus.miss_ready_o = 1'b1;
        bus.plru_set_o   = bus.miss_set_i;
        if (bus.miss_valid_i) state_d = ST_VICT;
      end
      ST_VICT: begin
        if (bus.valid_i[bus.victim_i]) begin
          bus.tag_rd_en_o  = 1'b1;
          bus.tag_rd_way_o = bus.victim_i;
          state_d          = ST_TAGRD;
        end else begin
          state_d = ST_ACQ;
        end
      end
      ST_TAGRD: state_d = ST_REL;
      ST_REL: begin
        bus.rel_valid_o = 1'b1;
        bus.rel_tag_o   = vtag_q;
        bus.rel_way_o   = victim_q;
        bus.rel_data_o  = dirty_q;
        // An ack coinciding with the accept would be lost in REL_WAIT.
        if (bus.rel_ready_i) state_d = bus.rel_ack_i ? ST_ACQ : ST_REL_WAIT;
      end
      ST_REL_WAIT: if (bus.rel_ack_i) state_d = ST_ACQ;
      ST_ACQ: begin
        bus.acq_valid_o = 1'b1;
        bus.acq_tag_o   = tag_q;
        bus.acq_way_o   = victim_q;
        if (bus.acq_ready_i) state_d = bus.grant_done_i ? ST_INST : ST_ACQ_WAIT;
      end
      ST_ACQ_WAIT: if (bus.grant_done_i) state_d = ST_INST;
      ST_INST: begin
        bus.inst_we_o     = 1'b1;
        bus.inst_way_o    = victim_q;
        bus.inst_tag_o    = tag_q;
        bus.plru_access_o = 1'b1;
        bus.plru_way_o    = victim_q;
        bus.done_o        = 1'b1;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu64_l1_refill_ctrl.sv
// Directed bench for the L1 refill controller: cold, dirty, clean/backpressure and reset-mid-miss cases.
module tb_cpu64_l1_refill_ctrl;
  import cpu64_l1_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpu64_l1_refill_ctrl_if #(.INDEX_W(5), .TAG_W(20)) bus ();

  cpu64_l1_refill_ctrl #(.INDEX_W(5), .TAG_W(20)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_miss_ready"}, 32'(bus.miss_ready_o), 32'd1);
    chk({tag, "_strobes"}, 32'({bus.rel_valid_o, bus.acq_valid_o, bus.tag_rd_en_o,
                                bus.inst_we_o, bus.plru_access_o, bus.done_o}), 32'd0);
    chk({tag, "_data"}, 32'(bus.rel_tag_o) | 32'(bus.acq_tag_o) | 32'(bus.inst_tag_o) |
                        32'(bus.rel_way_o) | 32'(bus.acq_way_o) | 32'(bus.inst_way_o) |
                        32'(bus.plru_way_o) | 32'(bus.tag_rd_way_o) | 32'(bus.rel_data_o) |
                        32'(bus.plru_set_o), 32'd0);
  endtask

  initial begin
    bus.miss_valid_i  = 1'b0;
    bus.miss_set_i    = '0;
    bus.miss_tag_i    = '0;
    bus.victim_i      = '0;
    bus.valid_i       = '0;
    bus.dirty_i       = '0;
    bus.tag_rd_data_i = '0;
    bus.rel_ready_i   = 1'b0;
    bus.rel_ack_i     = 1'b0;
    bus.acq_ready_i   = 1'b0;
    bus.grant_done_i  = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_idle_outputs("reset");

    // Cold set: invalid victim 0, no release.
    bus.valid_i = 8'h00; bus.victim_i = 3'd0;
    bus.miss_set_i = 5'd7; bus.miss_tag_i = 20'h12345; bus.miss_valid_i = 1'b1;
    tick();                                   // VICT
    bus.miss_valid_i = 1'b0; bus.miss_set_i = 5'd0;
    chk("cold_vict_set", 32'(bus.plru_set_o), 32'd7);
    chk("cold_vict_ready", 32'(bus.miss_ready_o), 32'd0);
    chk("cold_vict_tagrd", 32'(bus.tag_rd_en_o), 32'd0);
    tick();                                   // ACQ
    chk("cold_acq_valid", 32'(bus.acq_valid_o), 32'd1);
    chk("cold_acq_tag", 32'(bus.acq_tag_o), 32'h12345);
    chk("cold_acq_way", 32'(bus.acq_way_o), 32'd0);
    chk("cold_no_rel", 32'(bus.rel_valid_o), 32'd0);
    bus.acq_ready_i = 1'b1;
    tick();                                   // ACQ_WAIT
    bus.acq_ready_i = 1'b0;
    chk("cold_acqwait_valid", 32'(bus.acq_valid_o), 32'd0);
    tick();
    chk("cold_wait_no_inst", 32'(bus.inst_we_o), 32'd0);
    bus.grant_done_i = 1'b1;
    tick();                                   // INST
    bus.grant_done_i = 1'b0;
    chk("cold_inst", 32'({bus.inst_we_o, bus.plru_access_o, bus.done_o}), 32'b111);
    chk("cold_inst_way", 32'(bus.inst_way_o), 32'd0);
    chk("cold_plru_way", 32'(bus.plru_way_o), 32'd0);
    chk("cold_inst_tag", 32'(bus.inst_tag_o), 32'h12345);
    chk("cold_inst_set", 32'(bus.plru_set_o), 32'd7);
    tick();                                   // IDLE
    chk("cold_back_idle", 32'(bus.miss_ready_o), 32'd1);
    chk("cold_done_once", 32'(bus.done_o), 32'd0);

    // Dirty victim way 3.
    bus.valid_i = 8'hFF; bus.dirty_i = 8'h08; bus.victim_i = 3'd3; bus.tag_rd_data_i = 20'hABCDE;
    bus.miss_set_i = 5'h11; bus.miss_tag_i = 20'h55555; bus.miss_valid_i = 1'b1;
    tick();                                   // VICT
    bus.miss_valid_i = 1'b0;
    chk("dirty_tagrd_en", 32'(bus.tag_rd_en_o), 32'd1);
    chk("dirty_tagrd_way", 32'(bus.tag_rd_way_o), 32'd3);
    chk("dirty_vict_set", 32'(bus.plru_set_o), 32'h11);
    tick();                                   // TAGRD
    bus.victim_i = 3'd6; bus.dirty_i = 8'h00;   // PLRU moves; victim must stay frozen
    chk("dirty_tagrd_pulse", 32'(bus.tag_rd_en_o), 32'd0);
    chk("dirty_tagrd_norel", 32'(bus.rel_valid_o), 32'd0);
    tick();                                   // REL
    chk("dirty_rel_valid", 32'(bus.rel_valid_o), 32'd1);
    chk("dirty_rel_tag", 32'(bus.rel_tag_o), 32'hABCDE);
    chk("dirty_rel_way", 32'(bus.rel_way_o), 32'd3);
    chk("dirty_rel_data", 32'(bus.rel_data_o), 32'(REL_DIRTY));
    bus.rel_ready_i = 1'b1;
    tick();                                   // REL_WAIT
    bus.rel_ready_i = 1'b0;
    bus.grant_done_i = 1'b1;                  // ignored outside ACQ_WAIT
    chk("dirty_relwait_rel", 32'(bus.rel_valid_o), 32'd0);
    chk("dirty_relwait_acq", 32'(bus.acq_valid_o), 32'd0);
    tick();
    bus.grant_done_i = 1'b0;
    chk("dirty_no_acq_before_ack", 32'(bus.acq_valid_o), 32'd0);
    chk("dirty_stray_grant", 32'(bus.inst_we_o), 32'd0);
    bus.rel_ack_i = 1'b1;
    tick();                                   // ACQ
    bus.rel_ack_i = 1'b0;
    chk("dirty_acq_valid", 32'(bus.acq_valid_o), 32'd1);
    chk("dirty_acq_way", 32'(bus.acq_way_o), 32'd3);
    chk("dirty_acq_tag", 32'(bus.acq_tag_o), 32'h55555);
    bus.acq_ready_i = 1'b1;
    tick();                                   // ACQ_WAIT
    bus.acq_ready_i = 1'b0;
    bus.grant_done_i = 1'b1;
    tick();                                   // INST
    bus.grant_done_i = 1'b0;
    chk("dirty_inst_we", 32'(bus.inst_we_o), 32'd1);
    chk("dirty_inst_way", 32'(bus.inst_way_o), 32'd3);
    chk("dirty_plru_way", 32'(bus.plru_way_o), 32'd3);
    chk("dirty_inst_tag", 32'(bus.inst_tag_o), 32'h55555);
    tick();
    chk("dirty_idle", 32'(bus.miss_ready_o), 32'd1);

    // Clean victim way 5 with release backpressure and same-cycle handshakes.
    bus.valid_i = 8'hFF; bus.dirty_i = 8'hDF; bus.victim_i = 3'd5; bus.tag_rd_data_i = 20'h0F0F0;
    bus.miss_set_i = 5'd3; bus.miss_tag_i = 20'h2468A; bus.miss_valid_i = 1'b1;
    tick();                                   // VICT
    bus.miss_valid_i = 1'b0;
    chk("clean_tagrd_way", 32'(bus.tag_rd_way_o), 32'd5);
    tick();                                   // TAGRD
    tick();                                   // REL
    bus.tag_rd_data_i = 20'hFFFFF; bus.victim_i = 3'd1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_rel_valid", 32'(bus.rel_valid_o), 32'd1);
      chk("bp_rel_fields", {bus.rel_tag_o, 1'b0, bus.rel_way_o, 7'd0, bus.rel_data_o},
          {20'h0F0F0, 1'b0, 3'd5, 7'd0, 1'b0});
      tick();
    end
    chk("bp_still_rel", 32'(bus.rel_valid_o), 32'd1);
    bus.rel_ready_i = 1'b1; bus.rel_ack_i = 1'b1;
    tick();                                   // ACQ directly
    bus.rel_ready_i = 1'b0; bus.rel_ack_i = 1'b0;
    chk("clean_one_accept", 32'(bus.rel_valid_o), 32'd0);
    chk("clean_same_ack_acq", 32'(bus.acq_valid_o), 32'd1);
    chk("clean_acq_way", 32'(bus.acq_way_o), 32'd5);
    bus.acq_ready_i = 1'b1; bus.grant_done_i = 1'b1;
    tick();                                   // INST directly
    bus.acq_ready_i = 1'b0; bus.grant_done_i = 1'b0;
    chk("same_inst", 32'({bus.inst_we_o, bus.done_o}), 32'b11);
    chk("clean_inst_way", 32'(bus.inst_way_o), 32'd5);
    chk("clean_inst_tag", 32'(bus.inst_tag_o), 32'h2468A);
    tick();
    chk("same_done_once", 32'(bus.done_o), 32'd0);
    chk("same_idle", 32'(bus.miss_ready_o), 32'd1);

    // Reset while in ACQ_WAIT, then a normal miss.
    bus.valid_i = 8'h00; bus.victim_i = 3'd2;
    bus.miss_set_i = 5'd9; bus.miss_tag_i = 20'h13579; bus.miss_valid_i = 1'b1;
    tick();                                   // VICT
    bus.miss_valid_i = 1'b0;
    tick();                                   // ACQ
    chk("rst_pre_acq", 32'(bus.acq_valid_o), 32'd1);
    bus.acq_ready_i = 1'b1;
    tick();                                   // ACQ_WAIT
    bus.acq_ready_i = 1'b0;
    bus.miss_set_i = 5'd0; bus.miss_tag_i = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_outputs("mid_reset");
    bus.grant_done_i = 1'b1;
    tick();
    bus.grant_done_i = 1'b0;
    chk("post_rst_ignore_grant", 32'({bus.inst_we_o, bus.acq_valid_o, bus.miss_ready_o}), 32'b001);
    bus.victim_i = 3'd1; bus.miss_set_i = 5'd4; bus.miss_tag_i = 20'h0BEEF; bus.miss_valid_i = 1'b1;
    tick();                                   // VICT
    bus.miss_valid_i = 1'b0;
    tick();                                   // ACQ
    chk("post_rst_acq_way", 32'(bus.acq_way_o), 32'd1);
    bus.acq_ready_i = 1'b1; bus.grant_done_i = 1'b1;
    tick();                                   // INST
    bus.acq_ready_i = 1'b0; bus.grant_done_i = 1'b0;
    chk("post_rst_inst_way", 32'(bus.inst_way_o), 32'd1);
    chk("post_rst_inst_tag", 32'(bus.inst_tag_o), 32'h0BEEF);
    chk("post_rst_done", 32'(bus.done_o), 32'd1);
    tick();
    chk("post_rst_idle", 32'(bus.miss_ready_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
